// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the shared data-memory port.
// One transaction in flight: grant, issue to memory until ack or timeout, then a one-cycle response.

module mem_port_resp #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          err_in,
  input  logic [DW-1:0] rdata_in,
  input  logic          ack_en,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          err
);
  // Response fields hold until the next response to this requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (load) begin
      rdata <= rdata_in;
      err   <= err_in;
    end
  end

  assign ack = ack_en;
endmodule

module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          err1,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int NREQ = 2;
  localparam int CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                     state, state_nxt;
  logic                       grant, last_grant, pick;
  logic [CW-1:0]              cnt;
  logic                       timeout_hit;
  logic                       resp_load, resp_err;
  logic [DW-1:0]              resp_rdata;

  logic [NREQ-1:0]            req_v, we_v, ack_v, err_v;
  logic [NREQ-1:0][AW-1:0]    addr_v;
  logic [NREQ-1:0][DW-1:0]    wdata_v, rdata_v;

  assign req_v   = {req1, req0};
  assign we_v    = {we1, we0};
  assign addr_v  = {addr1, addr0};
  assign wdata_v = {wdata1, wdata0};

  // On a tie the requester that did not win last time gets the port.
  assign pick        = req_v[1] & (~req_v[0] | ~last_grant);
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    resp_load  = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state)
      IDLE:  if (|req_v) state_nxt = ISSUE;
      ISSUE: begin
        // Ack takes priority over a coincident timeout.
        if (mem_ack) begin
          state_nxt  = RESP;
          resp_load  = 1'b1;
          resp_rdata = mem_we ? '0 : mem_rdata;
        end else if (timeout_hit) begin
          state_nxt = RESP;
          resp_load = 1'b1;
          resp_err  = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (|req_v) begin
          mem_req    <= 1'b1;
          mem_we     <= we_v[pick];
          mem_addr   <= addr_v[pick];
          mem_wdata  <= wdata_v[pick];
          grant      <= pick;
          last_grant <= pick;
          cnt        <= '0;
        end
        ISSUE: begin
          if (resp_load) mem_req <= 1'b0;
          else           cnt     <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    mem_port_resp #(.DW(DW)) u_resp (
      .clk     (clk),
      .rst     (rst),
      .load    (resp_load && (grant == 1'(i))),
      .err_in  (resp_err),
      .rdata_in(resp_rdata),
      .ack_en  ((state == RESP) && (grant == 1'(i))),
      .ack     (ack_v[i]),
      .rdata   (rdata_v[i]),
      .err     (err_v[i])
    );
  end

  assign ack0   = ack_v[0];
  assign ack1   = ack_v[1];
  assign rdata0 = rdata_v[0];
  assign rdata1 = rdata_v[1];
  assign err0   = err_v[0];
  assign err1   = err_v[1];
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter that shares the single data-memory port. Requester 0 is the load_store_queue memory interface; requester 1 is the secondary memory master (instruction-fetch refill or debug access). The arbiter registers the granted request and drives the memory request until it is acknowledged or times out. It then returns a one-cycle ack with read data to the granted requester. Round-robin fairness applies on contention.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max cycles in ISSUE without mem_ack before an error response (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req0  in  1  requester 0 request; held with we0/addr0/wdata0 stable until ack0
we0  in  1  requester 0 write enable (1=store, 0=load)
addr0  in  AW  requester 0 address
wdata0  in  DW  requester 0 store data
ack0  out  1  one-cycle completion pulse to requester 0
rdata0  out  DW  load data to requester 0, valid with ack0
err0  out  1  timeout flag, valid with ack0
req1, we1, addr1, wdata1  in  1/1/AW/DW  requester 1, same rules
ack1, rdata1, err1  out  1/DW/1  requester 1, same rules
mem_req  out  1  registered request to memory
mem_we  out  1  registered write enable
mem_addr  out  AW  registered address
mem_wdata  out  DW  registered store data
mem_ack  in  1  memory completion, sampled while mem_req=1
mem_rdata  in  DW  memory read data, valid with mem_ack
busy  out  1  high in ISSUE or RESP

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; last_grant=1, so requester 0 wins the first tie; timeout counter=0. Reset mid-transaction drops mem_req immediately. No ack is issued for the aborted request.
- States: IDLE, ISSUE, RESP.
- IDLE: if no request is pending, stay in IDLE.
  - Only one request pending: grant it.
  - Both pending: grant the requester != last_grant.
  - On the grant edge: capture we/addr/wdata into mem_* regs, set mem_req=1, record grant and last_grant, clear the counter, go to ISSUE.
- ISSUE: mem_req held 1 and mem_* stable.
  - mem_ack=1: capture mem_rdata (for loads; 0 for stores) into the granted rdataX, errX=0. Drop mem_req. Go to RESP.
  - Otherwise, if counter==TIMEOUT-1: drop mem_req, rdataX=0, errX=1, go to RESP.
  - Otherwise: counter+1.
  - mem_ack and timeout in the same cycle: ack wins, errX=0.
- RESP: ackX=1 for exactly one cycle for the granted requester only; the other ack stays 0. Next state is IDLE unconditionally.
- rdataX/errX hold their values until the next response to that requester.
- Latency: request seen at edge N in IDLE -> mem_req high from N+1. mem_ack sampled at edge M -> ackX high during cycle M+1. Minimum request-to-ack is 3 cycles.
- Requester contract: deassert reqX (or present a new request) by the edge following the ackX cycle. IDLE re-samples at that edge, so one idle cycle separates transactions.
- A requester's request pending in IDLE is never starved: after one opposing grant it wins the next tie.
- mem_ack outside ISSUE is ignored.
- Request fields are sampled only at the grant edge; later changes to them are ignored until ack.

Test Plan:
- Single load: req0=1, we0=0, addr0=0x100. mem_ack=1 with mem_rdata=0xDEADBEEF on the 3rd ISSUE cycle -> mem_addr=0x100, mem_we=0; ack0 pulses one cycle later with rdata0=0xDEADBEEF, err0=0; ack1 stays 0.
- Tie after reset: req0 store (addr 0x10, data 0x5) and req1 load (addr 0x20) asserted together -> requester 0 served first (mem_we=1, mem_wdata=0x5), then requester 1 (mem_addr=0x20); ack0 precedes ack1.
- Round-robin: both requesters continuously re-request for 4 transactions, memory acks after 1 cycle -> grant order 0,1,0,1; each ack exactly 3 cycles after its grant edge.
- Timeout: TIMEOUT=16, req1 load, mem_ack held 0 -> mem_req high for exactly 16 cycles, then ack1=1, err1=1, rdata1=0; the next transaction completes normally with err=0.
- Ack/timeout coincidence: mem_ack=1 on the 16th ISSUE cycle with mem_rdata=0x1234 -> err=0, rdata=0x1234.
- Reset mid-operation: assert rst during ISSUE -> mem_req, busy, ack0/ack1 drop to 0 within the same cycle; after release, a new req0 is granted first and completes normally.
